// File: rtl/qsys_input_pio_edge_capture.sv
// Avalon-MM input PIO: synchronises external inputs, latches edges per bit and raises a maskable level IRQ.
// Optional input debouncing is enabled by defining QSYS_INPUT_PIO_DEBOUNCE_EN.
module qsys_input_pio_edge_capture #(
  parameter int WIDTH           = 18,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] syncStage1_q;
  logic [WIDTH-1:0] syncStage2_q;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edgeDet;
  logic [WIDTH-1:0] clearMask;
  logic [WIDTH-1:0] edgeCap_q;
  logic [WIDTH-1:0] edgeCap_d;
  logic [WIDTH-1:0] irqMask_q;
  logic [WIDTH-1:0] irqMask_d;
  logic [31:0]      readData_q;
  logic [31:0]      readData_d;
  logic             wrEn;
  logic             unusedBits;

  // Upper write-data bits and the debounce period are not needed in every build.
  assign unusedBits = ^{writedata, DEBOUNCE_CYCLES};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncStage1_q <= '0;
      syncStage2_q <= '0;
    end else begin
      syncStage1_q <= in_port;
      syncStage2_q <= syncStage1_q;
    end
  end

`ifdef QSYS_INPUT_PIO_DEBOUNCE_EN
  localparam int CntW = $clog2(DEBOUNCE_CYCLES);

  logic [CntW-1:0]  dbCount_q;
  logic [CntW-1:0]  dbCount_d;
  logic             dbTick;
  logic [WIDTH-1:0] dbSamp_q;
  logic [WIDTH-1:0] dbAgree;
  logic [WIDTH-1:0] filtered_q;
  logic [WIDTH-1:0] filtered_d;

  // A bit only follows the synchroniser when two consecutive tick samples agree.
  always_comb begin
    dbTick     = (dbCount_q == CntW'(DEBOUNCE_CYCLES - 1));
    dbCount_d  = dbTick ? '0 : dbCount_q + CntW'(1);
    dbAgree    = ~(syncStage2_q ^ dbSamp_q);
    filtered_d = filtered_q;
    if (dbTick) begin
      filtered_d = (dbAgree & syncStage2_q) | (~dbAgree & filtered_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbCount_q  <= '0;
      dbSamp_q   <= '0;
      filtered_q <= '0;
    end else begin
      dbCount_q  <= dbCount_d;
      filtered_q <= filtered_d;
      if (dbTick) begin
        dbSamp_q <= syncStage2_q;
      end
    end
  end

  assign filtered = filtered_q;
`else
  assign filtered = syncStage2_q;
`endif

  assign wrEn = chipselect & ~write_n;

  // Edge capture is sticky; a new edge wins over a simultaneous write-1-to-clear.
  always_comb begin
    case (EDGE_TYPE)
      0:       edgeDet = filtered & ~prev_q;
      1:       edgeDet = ~filtered & prev_q;
      default: edgeDet = filtered ^ prev_q;
    endcase
    clearMask = '0;
    if (wrEn && (address == 2'd3)) begin
      clearMask = writedata[WIDTH-1:0];
    end
    edgeCap_d = (edgeCap_q & ~clearMask) | edgeDet;
    irqMask_d = irqMask_q;
    if (wrEn && (address == 2'd2)) begin
      irqMask_d = writedata[WIDTH-1:0];
    end
  end

  // Read data is registered unconditionally; the interconnect qualifies reads.
  always_comb begin
    case (address)
      2'd0:    readData_d = 32'(filtered);
      2'd2:    readData_d = 32'(irqMask_q);
      2'd3:    readData_d = 32'(edgeCap_q);
      default: readData_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      edgeCap_q  <= '0;
      irqMask_q  <= '0;
      readData_q <= '0;
    end else begin
      prev_q     <= filtered;
      edgeCap_q  <= edgeCap_d;
      irqMask_q  <= irqMask_d;
      readData_q <= readData_d;
    end
  end

  assign readdata = readData_q;
  assign irq      = |(edgeCap_q & irqMask_q);

endmodule
